// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-way stream multiplexer.
//   MODE_FIXED / MODE_RR : values of the mode input.
//   first_set_rot()      : index of the first set request bit, searching
//                          upward from a start index and wrapping at n.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // The search function works on a fixed 16-entry vector so one
  // definition serves every CHANNELS value the mux supports.
  localparam int MAX_CHANNELS = 16;
  localparam int IDX_W        = 5;

  // Returns the first index i (in the order start, start+1, ..., wrapping
  // modulo n) with req[i] set. Returns 0 when nothing is requested; callers
  // qualify the result with |req.
  function automatic logic [IDX_W-1:0] first_set_rot(
    input logic [MAX_CHANNELS-1:0] req,
    input logic [IDX_W-1:0]        start,
    input logic [IDX_W-1:0]        n
  );
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pos;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_CHANNELS; k++) begin
      // start < n and k < n, so a single subtraction folds pos into range.
      pos = start + IDX_W'(k);
      if (pos >= n) pos = pos - n;
      if (!found && (IDX_W'(k) < n) && req[pos[3:0]]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_mux_nway_rr_arbiter.sv
// Round-robin arbiter for the N-way stream multiplexer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-channel request (channel valid)
//   advance    : the current grant was consumed; move priority past it
//   grant      : one-hot grant, zero when nothing is requested
//   grant_idx  : index of the granted channel (0 when nothing is requested)
// The pointer holds the last served channel; the search starts one above it.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]        ptr_q, ptr_d;
  logic [SEL_W-1:0]        start;
  logic [MAX_CHANNELS-1:0] req_ext;
  logic [IDX_W-1:0]        idx_full;
  logic                    unused_idx_hi;

  always_comb begin
    start = (ptr_q == LAST) ? '0 : ptr_q + SEL_W'(1);
    req_ext = '0;
    req_ext[CHANNELS-1:0] = req;
    idx_full  = first_set_rot(req_ext, IDX_W'(start), IDX_W'(CHANNELS));
    grant_idx = idx_full[SEL_W-1:0];
    grant = '0;
    if (|req) grant[grant_idx] = 1'b1;
    ptr_d = advance ? grant_idx : ptr_q;
  end

  // Upper index bits are always zero for the configured channel count.
  assign unused_idx_hi = ^idx_full[IDX_W-1:SEL_W];

  // Reset to the last channel so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= LAST;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/stream_mux_nway.sv
// N-way valid/ready stream multiplexer with a one-entry output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   mode       : 0 = fixed select via sel, 1 = round-robin among valid inputs
//   sel        : channel index used in fixed mode (>= CHANNELS grants nothing)
//   in_data    : flattened inputs, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready, one-hot or zero
//   out_data   : registered selected word
//   out_valid  : out_data holds a word not yet taken
//   out_ready  : consumer accepts out_data
//   out_chan   : channel that produced out_data
module stream_mux_nway
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_W-1:0]    out_chan_q, out_chan_d;

  logic                can_load;
  logic [CHANNELS-1:0] fix_grant;
  logic [CHANNELS-1:0] rr_grant;
  logic [SEL_W-1:0]    rr_idx;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                xfer_in;
  logic                rr_advance;
  logic [WIDTH-1:0]    sel_data;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (rr_advance),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // The register can take a word when empty or when its word leaves this
  // cycle; this is the only out_ready -> in_ready path.
  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    fix_grant = '0;
    if (int'(sel) < CHANNELS) fix_grant[sel] = in_valid[sel];

    if (mode == MODE_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
    end else begin
      grant     = fix_grant;
      grant_idx = sel;
    end

    // Held low during reset so no producer sees a handshake.
    in_ready = rst_n ? (grant & {CHANNELS{can_load}}) : '0;
    xfer_in  = |(in_valid & in_ready);
    // Only an RR-mode transfer moves the priority pointer.
    rr_advance = xfer_in && (mode == MODE_RR);

    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end

    out_valid_d = xfer_in || (out_valid_q && !out_ready);
    out_data_d  = xfer_in ? sel_data  : out_data_q;
    out_chan_d  = xfer_in ? grant_idx : out_chan_q;
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule

// File: doc/stream_mux_nway.md
Name: stream_mux_nway

Overview:
- Parametrised successor to the combinational 8-way/16-bit mux in the CPU datapath.
- Selects one of CHANNELS valid/ready input streams of WIDTH bits and registers the chosen word into a one-entry output pipeline stage.
- Two selection modes:
  - fixed: an external select picks the channel.
  - round-robin: a fair arbiter picks among valid channels.
- Sits between multiple producers (register file read ports, memory-mapped sources) and a single consumer.

Parameters:
- WIDTH, 16, data width of every channel and of the output.
- CHANNELS, 8, number of input channels (2..16, need not be a power of 2).
- SEL_W, $clog2(CHANNELS), localparam, width of select and channel index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- in_data  input  CHANNELS*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an untaken word.
- out_ready  input  1  consumer accepts out_data.
- out_chan  output  SEL_W  channel index that produced out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr pointer=CHANNELS-1 so channel 0 has first priority. in_ready is 0 while rst_n=0.
- Reset mid-operation: any held word is discarded and never delivered.
- can_load = !out_valid | out_ready. This is the only combinational path from out_ready to in_ready.
- Grant (combinational, at most one channel):
  - Fixed mode: grant[sel] = in_valid[sel], provided sel < CHANNELS. If sel >= CHANNELS, no grant.
  - RR mode: the first valid channel searching from ptr+1 upward, wrapping modulo CHANNELS.
- in_ready = grant & {CHANNELS{can_load}}.
- Transfer in on channel i when in_valid[i] & in_ready[i]. On the next edge: out_data = channel i data, out_chan = i, out_valid = 1.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle when out_ready is held high.
- Output hold: if out_valid & !out_ready, out_data and out_chan stay stable and all in_ready = 0 (no overwrite).
- Output transfer with no new input: out_valid drops to 0 on the next edge.
- Simultaneous output and input transfer in the same cycle: the register reloads and out_valid stays 1.
- RR pointer:
  - Updates to the granted index only on an input transfer.
  - Unchanged on stalls, in fixed mode, and on idle cycles.
  - Retained across mode switches.
- Changes to mode or sel take effect combinationally for the next grant; they never alter a word already held.
- No valid inputs: no grant, and out_valid clears once drained.
- Input side must not depend on out_valid combinationally in a way that creates a loop. Consumer rules: out_ready may depend on out_valid; in_valid must not depend on in_ready.

Decomposition:
- Package stream_mux_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - A function for the index of the first set bit in a rotated request vector.
- Sub-module rr_arbiter (parameter CHANNELS):
  - Inputs: req, advance, clk, rst_n.
  - Outputs: one-hot grant, grant index.
  - Owns the pointer register and its reset value.
- Top level contains the fixed/RR selection, the output register and the handshake.

Test Plan:
- Reset values: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0x0000, out_chan=0, in_ready=0x00. Release -> no spurious transfer before the first clk edge.
- Fixed mode sweep: inputs a..h = 0x1234, 0x2345, 0x3456, 0x4567, 0x5678, 0x6789, 0x789A, 0x89AB; all valid; out_ready=1; sel stepping 0..7 -> one cycle later out_data equals the selected word and out_chan=sel. in_ready is one-hot at bit sel.
- Round-robin fairness: mode=1, in_valid=0xFF, out_ready=1 for 10 cycles -> out_chan sequence 0,1,...,7,0,1. With in_valid=0x24 -> alternates 2,5,2,5.
- Backpressure: out_ready=0 after the first word (0x1234) -> out_data holds 0x1234 and in_ready=0x00 for 5 cycles. Raise out_ready -> 0x2345 appears the next cycle with no loss or duplication.
- Out-of-range select: CHANNELS=6, mode=0, sel=7, all valid -> in_ready=0x00 and out_valid stays 0.
- Mid-stream reset: assert rst_n=0 asynchronously between edges while out_valid=1 -> out_valid falls immediately. After release, RR restarts at channel 0.
